iterative_multiplier: RTL

Multi-cycle shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits in the execute stage beside the ALU adder and consumes the same operand_a/operand_b pair. It performs one N-bit add plus one shift per cycle, reusing ripple-carry add semantics with the carry-out kept as the (N+1)th bit. The pipeline stalls on busy and captures result on done.

---
 rtl/iterative_multiplier.sv | 134 +++++++++++++
 1 files changed

// File: rtl/iterative_multiplier.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied one bit per cycle with an
// N-bit add whose carry is kept as bit N, then the sign is re-applied.
module iterative_multiplier #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   mag_a_q, mag_a_d;
  logic           neg_q, neg_d;
  logic [N:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]  count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   result_q, result_d;

  logic           sign_a, sign_b;
  logic [N-1:0]   abs_a, abs_b;
  logic [N:0]     sum;
  logic [2*N-1:0] prod, prod_fixed;
  logic [N-1:0]   sel;

  // Operand magnitudes, per-cycle partial sum and final signed product select
  always_comb begin
    sign_a     = operand_a[N-1] & ((op == 2'b01) || (op == 2'b10));
    sign_b     = operand_b[N-1] & (op == 2'b01);
    abs_a      = sign_a ? -operand_a : operand_a;
    abs_b      = sign_b ? -operand_b : operand_b;
    sum        = acc_lo_q[0] ? ({1'b0, acc_hi_q[N-1:0]} + {1'b0, mag_a_q}) : acc_hi_q;
    prod       = {acc_hi_q[N-1:0], acc_lo_q};
    // Negating zero yields zero, so a "negative zero" product needs no special case
    prod_fixed = neg_q ? -prod : prod;
    sel        = (op_q == 2'b00) ? prod_fixed[N-1:0] : prod_fixed[2*N-1:N];
  end

  // Next-state and datapath update for the IDLE/RUN/FIN sequencer
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_a_d  = mag_a_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d     = op;
          mag_a_d  = abs_a;
          neg_d    = sign_a ^ sign_b;
          acc_hi_d = '0;
          acc_lo_d = abs_b;
          count_d  = CW'(N);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift {sum, acc_lo} right by one; the carry lands in acc_hi[N-1]
        acc_hi_d = {1'b0, sum[N:1]};
        acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
        count_d  = count_q - 1'b1;
        busy_d   = 1'b1;
        if (count_q == CW'(1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        result_d = sel;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mag_a_q  <= '0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_a_q  <= mag_a_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Result is visible combinationally in FIN and held in result_q afterwards
  always_comb begin
    busy   = busy_q;
    done   = done_q;
    result = (state_q == FIN) ? sel : result_q;
  end

endmodule
